// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default widths, channel encoding and the stereo
// frame payload used by both the transmit and receive paths.
package i2s_pkg;

  localparam int unsigned DATA_W_DEF    = 24;
  localparam int unsigned SLOT_BITS_DEF = 32;

  // Word-select encoding as it appears on lrclk.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } frame_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Stereo sample handshake between the DSP (master) and the I2S transmitter (slave).
//   din_l/din_r : left/right sample
//   din_valid   : producer presents a frame
//   din_ready   : consumer can accept a frame this cycle
interface i2s_transmitter_if #(
  parameter int unsigned DATA_W = i2s_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] din_l;
  logic [DATA_W-1:0] din_r;
  logic              din_valid;
  logic              din_ready;

  modport master (output din_l, output din_r, output din_valid, input din_ready);
  modport slave  (input din_l, input din_r, input din_valid, output din_ready);
endinterface

// File: rtl/i2s_tx_holdbuf.sv
// One-entry stereo frame holding buffer.
//   clk, rst_n : clock, async active-low reset
//   din_if     : valid/ready frame input (slave side)
//   drain      : strobe emptying the buffer; the holder has taken the frame
//   hold_l/r   : buffered frame
//   hold_full  : buffer holds a frame
module i2s_tx_holdbuf
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  i2s_transmitter_if.slave    din_if,
  input  logic                drain,
  output logic [DATA_W-1:0]   hold_l,
  output logic [DATA_W-1:0]   hold_r,
  output logic                hold_full
);

  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              full_q, full_d;

  // Ready is low while full, so capture and drain never happen together.
  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    full_d   = full_q;
    if (drain) begin
      full_d = 1'b0;
    end else if (din_if.din_valid && !full_q) begin
      hold_l_d = din_if.din_l;
      hold_r_d = din_if.din_r;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
      full_q   <= 1'b0;
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      full_q   <= full_d;
    end
  end

  assign din_if.din_ready = ~full_q;
  assign hold_l           = hold_l_q;
  assign hold_r           = hold_r_q;
  assign hold_full        = full_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: buffers one stereo frame and serialises it MSB-first
// on sdout with standard I2S framing (MSB one sclk after each lrclk edge).
//   sclk     : bit clock, all logic on posedge
//   rst      : async active-low reset
//   din_if   : stereo frame valid/ready input
//   lrclk    : word select, 0 = left, 1 = right
//   sdout    : serial data
//   underrun : one-cycle pulse when a left slot starts with nothing buffered
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic             sclk,
  input  logic             rst,
  i2s_transmitter_if.slave din_if,
  output logic             lrclk,
  output logic             sdout,
  output logic             underrun
);

  localparam int unsigned CNT_W = $clog2(SLOT_BITS);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  chan_e             chan_q, chan_d;
  logic              sdout_q, sdout_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] act_r_q, act_r_d;

  logic              wrap, into_left, into_right, drain;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic              hold_full;

  i2s_tx_holdbuf #(.DATA_W(DATA_W)) u_holdbuf (
    .clk       (sclk),
    .rst_n     (rst),
    .din_if    (din_if),
    .drain     (drain),
    .hold_l    (hold_l),
    .hold_r    (hold_r),
    .hold_full (hold_full)
  );

  // Slot counter, word select and serialiser.
  always_comb begin
    wrap       = (bit_cnt_q == CNT_W'(SLOT_BITS - 1));
    into_left  = wrap && (chan_q == RIGHT);
    into_right = wrap && (chan_q == LEFT);
    drain      = into_left && hold_full;

    bit_cnt_d  = wrap ? '0 : bit_cnt_q + CNT_W'(1);
    chan_d     = wrap ? chan_e'(~chan_q) : chan_q;
    sdout_d    = 1'b0;
    underrun_d = 1'b0;
    shreg_d    = shreg_q;
    act_r_d    = act_r_q;

    if (into_left) begin
      // Whole frame is taken at left start so left/right never mix frames.
      if (hold_full) begin
        shreg_d = hold_l;
        act_r_d = hold_r;
      end else begin
        shreg_d    = '0;
        act_r_d    = '0;
        underrun_d = 1'b1;
      end
    end else if (into_right) begin
      shreg_d = act_r_q;
    end else if (bit_cnt_d <= CNT_W'(DATA_W)) begin
      // Not wrapping, so bit_cnt_d is 1..DATA_W here: data bit slot.
      sdout_d = shreg_q[DATA_W-1];
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= CNT_W'(SLOT_BITS - 1);
      chan_q     <= RIGHT;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
      shreg_q    <= '0;
      act_r_q    <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      chan_q     <= chan_d;
      sdout_q    <= sdout_d;
      underrun_q <= underrun_d;
      shreg_q    <= shreg_d;
      act_r_q    <= act_r_d;
    end
  end

  assign lrclk    = chan_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with a loopback I2S receiver model.
module tb_i2s_transmitter;

  localparam int unsigned DW = 24;
  localparam int unsigned SB = 32;

  logic sclk;
  logic rst;
  logic lrclk;
  logic sdout;
  logic underrun;

  int n_checks;
  int n_fail;

  i2s_transmitter_if #(.DATA_W(DW)) din_if ();

  i2s_transmitter #(.DATA_W(DW), .SLOT_BITS(SB)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .din_if   (din_if),
    .lrclk    (lrclk),
    .sdout    (sdout),
    .underrun (underrun)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Loopback receiver: edge seen one cycle after lrclk toggles, then DW bits.
  logic          rx_prev_lr;
  int            rx_cnt;
  logic [DW-1:0] rx_sh;
  logic [DW-1:0] rx_q[$];

  initial begin
    rx_prev_lr = 1'b1;
    rx_cnt     = 0;
    rx_sh      = '0;
  end

  always @(negedge sclk) begin
    if (lrclk !== rx_prev_lr) begin
      rx_cnt = 1;
    end else if (rx_cnt >= 1 && rx_cnt <= int'(DW)) begin
      rx_sh = {rx_sh[DW-2:0], sdout};
      if (rx_cnt == int'(DW)) rx_q.push_back(rx_sh);
      rx_cnt++;
    end else begin
      rx_cnt = 0;
    end
    rx_prev_lr = lrclk;
  end

  task automatic wait_left_start(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = lrclk;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk);
      if (prev === 1'b1 && lrclk === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = lrclk;
    end
  endtask

  task automatic collect_word(output logic [DW-1:0] w);
    w = '0;
    for (int i = 0; i < int'(DW); i++) begin
      @(negedge sclk);
      w = {w[DW-2:0], sdout};
    end
  endtask

  task automatic test_reset;
    rst              = 1'b0;
    din_if.din_valid = 1'b0;
    din_if.din_l     = '0;
    din_if.din_r     = '0;
    repeat (3) @(negedge sclk);
    n_checks++; if (lrclk !== 1'b1) begin n_fail++; $display("FAIL reset_lrclk: got %b expected 1", lrclk); end
    n_checks++; if (sdout !== 1'b0) begin n_fail++; $display("FAIL reset_sdout: got %b expected 0", sdout); end
    n_checks++; if (din_if.din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", din_if.din_ready); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    rst = 1'b1;
    @(negedge sclk);
    n_checks++; if (lrclk !== 1'b0) begin n_fail++; $display("FAIL first_edge_lrclk: got %b expected 0", lrclk); end
    n_checks++; if (dut.bit_cnt_q !== 5'd0) begin n_fail++; $display("FAIL first_edge_bitcnt: got %0d expected 0", dut.bit_cnt_q); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL first_edge_underrun: got %b expected 1", underrun); end
  endtask

  task automatic test_single;
    bit            ok;
    logic [DW-1:0] w;
    din_if.din_l     = 24'hA5F00F;
    din_if.din_r     = 24'h123456;
    din_if.din_valid = 1'b1;
    @(negedge sclk);
    n_checks++; if (din_if.din_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_low: got %b expected 0", din_if.din_ready); end
    din_if.din_valid = 1'b0;
    wait_left_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_wait: got timeout expected left start"); end
    rx_q.delete();
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL single_underrun: got %b expected 0", underrun); end
    collect_word(w);
    n_checks++; if (w !== 24'hA5F00F) begin n_fail++; $display("FAIL single_left: got %h expected a5f00f", w); end
    repeat (8) @(negedge sclk);
    n_checks++; if (lrclk !== 1'b1) begin n_fail++; $display("FAIL single_right_lrclk: got %b expected 1", lrclk); end
    collect_word(w);
    n_checks++; if (w !== 24'h123456) begin n_fail++; $display("FAIL single_right: got %h expected 123456", w); end
    repeat (2) @(negedge sclk);
    n_checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 24'hA5F00F || rx_q[1] !== 24'h123456) begin
      n_fail++;
      $display("FAIL single_loopback: got %0d words first %h expected 2 words a5f00f,123456",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 24'h0);
    end
  endtask

  task automatic test_back_to_back;
    int   n, t, ur, bad;
    int   acc_t[$];
    logic rdy_prev;
    n = 0; t = 0; ur = 0; bad = 0;
    rx_q.delete();
    din_if.din_l     = 24'h100000;
    din_if.din_r     = 24'h200000;
    din_if.din_valid = 1'b1;
    rdy_prev         = din_if.din_ready;
    while (rx_q.size() < 16 && t < 1200) begin
      @(negedge sclk);
      t++;
      if (din_if.din_valid && rdy_prev) begin
        acc_t.push_back(t);
        n++;
        if (n == 8) din_if.din_valid = 1'b0;
        else begin
          din_if.din_l = 24'h100000 + DW'(n);
          din_if.din_r = 24'h200000 + DW'(n);
        end
      end
      if (underrun === 1'b1) ur++;
      rdy_prev = din_if.din_ready;
    end
    n_checks++; if (acc_t.size() != 8) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 8", acc_t.size()); end
    for (int i = 2; i < acc_t.size(); i++) if (acc_t[i] - acc_t[i-1] != 64) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_ready_period: got %0d bad intervals expected 0", bad); end
    n_checks++; if (ur != 0) begin n_fail++; $display("FAIL b2b_underrun: got %0d pulses expected 0", ur); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rx_q.size() < 2*i + 2) bad++;
      else if (rx_q[2*i] !== 24'h100000 + DW'(i) || rx_q[2*i+1] !== 24'h200000 + DW'(i)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_order: got %0d wrong frames expected 0", bad); end
  endtask

  task automatic test_underrun;
    int ur_t[$];
    int ones, bad;
    ones = 0; bad = 0;
    for (int t = 1; t <= 190; t++) begin
      @(negedge sclk);
      if (underrun === 1'b1) ur_t.push_back(t);
      if (sdout !== 1'b0) ones++;
    end
    n_checks++; if (ur_t.size() != 3) begin n_fail++; $display("FAIL underrun_count: got %0d expected 3", ur_t.size()); end
    for (int i = 1; i < ur_t.size(); i++) if (ur_t[i] - ur_t[i-1] != 64) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL underrun_period: got %0d bad intervals expected 0", bad); end
    n_checks++; if (ones != 0) begin n_fail++; $display("FAIL underrun_sdout: got %0d ones expected 0", ones); end
  endtask

  task automatic test_backpressure;
    bit            ok;
    logic [DW-1:0] w;
    n_checks++; if (din_if.din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty: got %b expected 1", din_if.din_ready); end
    din_if.din_l     = 24'hC3C3C3;
    din_if.din_r     = 24'h0F0F0F;
    din_if.din_valid = 1'b1;
    @(negedge sclk);
    din_if.din_l = 24'h3C3C3C;
    din_if.din_r = 24'hF0F0F0;
    repeat (3) begin
      n_checks++; if (din_if.din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", din_if.din_ready); end
      @(negedge sclk);
    end
    din_if.din_valid = 1'b0;
    wait_left_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_wait: got timeout expected left start"); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL bp_underrun: got %b expected 0", underrun); end
    collect_word(w);
    n_checks++; if (w !== 24'hC3C3C3) begin n_fail++; $display("FAIL bp_left: got %h expected c3c3c3", w); end
    repeat (8) @(negedge sclk);
    collect_word(w);
    n_checks++; if (w !== 24'h0F0F0F) begin n_fail++; $display("FAIL bp_right: got %h expected 0f0f0f", w); end
  endtask

  task automatic test_midword_reset;
    bit            ok;
    logic [DW-1:0] w;
    din_if.din_l     = 24'hFFFFFF;
    din_if.din_r     = 24'hFFFFFF;
    din_if.din_valid = 1'b1;
    @(negedge sclk);
    din_if.din_valid = 1'b0;
    wait_left_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mw_wait: got timeout expected left start"); end
    repeat (10) @(negedge sclk);
    n_checks++; if (sdout !== 1'b1) begin n_fail++; $display("FAIL mw_bit10: got %b expected 1", sdout); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (sdout !== 1'b0) begin n_fail++; $display("FAIL mw_sdout_async: got %b expected 0", sdout); end
    n_checks++; if (lrclk !== 1'b1) begin n_fail++; $display("FAIL mw_lrclk_async: got %b expected 1", lrclk); end
    n_checks++; if (din_if.din_ready !== 1'b1) begin n_fail++; $display("FAIL mw_ready_async: got %b expected 1", din_if.din_ready); end
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);
    n_checks++; if (lrclk !== 1'b0) begin n_fail++; $display("FAIL mw_relrclk: got %b expected 0", lrclk); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL mw_underrun: got %b expected 1", underrun); end
    collect_word(w);
    n_checks++; if (w !== 24'h000000) begin n_fail++; $display("FAIL mw_not_resumed: got %h expected 000000", w); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_backpressure();
    test_midword_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
